// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver that turns E0/F0-prefixed scan codes into {ext, release, code} events queued in a FIFO.
// Optional build macro PS2_TIMEOUT_EN aborts a stalled partial frame after TIMEOUT_CYCLES idle clocks.
module ps2_kbd_event_rx #(
  parameter int FIFO_AW        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_release,
  output logic             ev_ext,
  output logic [FIFO_AW:0] ev_count,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clear_err
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} dec_state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic                   frame_rdy_q, frame_rdy_d;
  dec_state_e             state_q, state_d;
  logic [FIFO_AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [9:0]             head_q, head_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic [9:0]             mem_q [DEPTH];

  logic             clk_cur, dat_cur, fall;
  logic             frame_ok, err_set, timeout;
  logic [7:0]       rx_byte;
  logic             emit;
  logic [9:0]       ev_data;
  logic [FIFO_AW:0] count;
  logic             full, empty, pop, push_acc, ovf_set;

  assign clk_cur  = clk_sync_q[SYNC_STAGES-1];
  assign dat_cur  = dat_sync_q[SYNC_STAGES-1];
  assign fall     = clk_prev_q & ~clk_cur;
  // shift_q holds {stop, parity, d7..d0} once the stop bit is in
  assign rx_byte  = shift_q[7:0];
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

  assign count = wptr_q - rptr_q;
  assign full  = (count == (FIFO_AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & ev_ready;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (!fall && bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                       to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_cur;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_rdy_d = 1'b0;
    state_d     = state_q;
    err_set     = 1'b0;
    emit        = 1'b0;
    ev_data     = {2'b00, rx_byte};

    if (fall) begin
      if (bit_cnt_q == 4'd0) begin
        if (!dat_cur) bit_cnt_d = 4'd1;
      end else begin
        shift_d = {dat_cur, shift_q[9:1]};
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_d   = 4'd0;
          frame_rdy_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
    end

    if (frame_rdy_q) begin
      if (!frame_ok) begin
        err_set = 1'b1;
        state_d = ST_IDLE;
      end else if (rx_byte == 8'hE0) begin
        state_d = (state_q == ST_F0) ? ST_E0 : ST_E0;
      end else if (rx_byte == 8'hF0) begin
        state_d = (state_q == ST_E0) ? ST_E0F0 : ST_F0;
      end else begin
        emit    = 1'b1;
        ev_data = {(state_q == ST_E0) || (state_q == ST_E0F0),
                   (state_q == ST_F0) || (state_q == ST_E0F0), rx_byte};
        state_d = ST_IDLE;
      end
    end

    if (timeout) begin
      bit_cnt_d = 4'd0;
      state_d   = ST_IDLE;
      err_set   = 1'b1;
    end

    push_acc = emit & (~full | pop);
    ovf_set  = emit & full & ~pop;
    wptr_d   = wptr_q + (FIFO_AW+1)'(push_acc);
    rptr_d   = rptr_q + (FIFO_AW+1)'(pop);

    // The register mirrors the next head; a freshly written slot is not yet in mem_q
    head_d = head_q;
    if (rptr_d != wptr_d) begin
      if (push_acc && rptr_d == wptr_q) head_d = ev_data;
      else                              head_d = mem_q[rptr_d[FIFO_AW-1:0]];
    end

    overflow_d  = ovf_set | (overflow_q  & ~clear_err);
    frame_err_d = err_set | (frame_err_q & ~clear_err);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      frame_rdy_q <= 1'b0;
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_rdy_q <= frame_rdy_d;
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      head_q      <= head_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: storage array is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q[FIFO_AW-1:0]] <= ev_data;
  end

  assign ev_valid   = ~empty;
  assign ev_code    = head_q[7:0];
  assign ev_release = head_q[8];
  assign ev_ext     = head_q[9];
  assign ev_count   = count;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Scoreboard bench for ps2_kbd_event_rx: stimulus pushes expected events, a negedge monitor pops on each handshake.
module tb_ps2_kbd_event_rx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic       ev_valid, ev_release, ev_ext, overflow, frame_err;
  logic [7:0] ev_code;
  logic [3:0] ev_count;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb [$];
  logic [9:0] mon_exp;

  ps2_kbd_event_rx #(.FIFO_AW(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_release(ev_release), .ev_ext(ev_ext), .ev_count(ev_count),
    .overflow(overflow), .frame_err(frame_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got 0x%0h with no event expected", {ev_ext, ev_release, ev_code});
      end else begin
        mon_exp = sb.pop_front();
        check("event", {ev_ext, ev_release, ev_code}, mon_exp);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 1: check ev_valid latency after this edge; mode 2: raise ev_ready in cycle E+1
  task automatic ps2_bit(input logic b, input int mode);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      tick(3);
      check("lat_e1_valid", ev_valid, 1'b0);
      tick(1);
      check("lat_e2_valid", ev_valid, 1'b1);
      tick(HALF - 4);
    end else if (mode == 2) begin
      tick(3);
      ev_ready = 1'b1;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit((~^b) ^ bad_par, 0);
    ps2_bit(1'b1, mode);
    tick(HALF);
  endtask

  task automatic send_bits(input int n, input logic [7:0] b);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < n - 1; i++) ps2_bit(b[i], 0);
  endtask

  task automatic exp_ev(input logic ext, input logic rel, input logic [7:0] code);
    sb.push_back({ext, rel, code});
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  initial begin
    tick(4);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_code", ev_code, 8'h00);
    check("rst_release", ev_release, 1'b0);
    check("rst_ext", ev_ext, 1'b0);
    check("rst_count", ev_count, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    clrn = 1'b1;
    tick(4);

    // Make code with latency check, then single-cycle pop
    exp_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1);
    check("make_count", ev_count, 4'd1);
    check("make_code", ev_code, 8'h1C);
    check("make_release", ev_release, 1'b0);
    check("make_ext", ev_ext, 1'b0);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("make_popped_valid", ev_valid, 1'b0);
    check("make_hold_code", ev_code, 8'h1C);
    tick(2);
    ev_ready = 1'b1;

    // Break, extended break, then plain make
    exp_ev(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    exp_ev(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h75, 1'b0, 0);
    exp_ev(1'b0, 1'b0, 8'h75);
    send_frame(8'h75, 1'b0, 0);
    tick(10);
    check("prefix_drained", sb.size(), 0);

    // Parity error drops the byte and resets the prefix state
    send_frame(8'h1C, 1'b1, 0);
    check("bad_par_err", frame_err, 1'b1);
    check("bad_par_count", ev_count, 4'd0);
    exp_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 0);
    pulse_clear();
    check("clear_frame_err", frame_err, 1'b0);

    // Overflow: ninth event dropped
    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_ev(1'b0, 1'b0, 8'(i));
      send_frame(8'(i), 1'b0, 0);
    end
    check("full_count", ev_count, 4'd8);
    check("full_overflow", overflow, 1'b1);
    check("full_head", ev_code, 8'h01);
    pulse_clear();
    check("clear_overflow", overflow, 1'b0);
    ev_ready = 1'b1;
    tick(20);
    check("drain_count", ev_count, 4'd0);

    // Push and pop in the same cycle while full
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) exp_ev(1'b0, 1'b0, 8'h11 + 8'(i));
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 0);
    check("full2_count", ev_count, 4'd8);
    send_frame(8'h19, 1'b0, 2);
    check("full_pushpop_overflow", overflow, 1'b0);
    tick(20);
    check("full2_drain_count", ev_count, 4'd0);

    // Reset mid-frame discards the partial frame
    send_bits(6, 8'hA5);
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    tick(2);
    check("midrst_count", ev_count, 4'd0);
    check("midrst_frame_err", frame_err, 1'b0);
    exp_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 0);

`ifdef PS2_TIMEOUT_EN
    send_bits(4, 8'h00);
    tick(40);
    check("timeout_early", frame_err, 1'b0);
    tick(80);
    check("timeout_err", frame_err, 1'b1);
    pulse_clear();
    exp_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 0);
`endif

    tick(50);
    check("final_sb_empty", sb.size(), 0);
    check("final_count", ev_count, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_event_rx.md
Name: ps2_kbd_event_rx

Overview:
Parametrised successor to the basic PS/2 keyboard receiver and reader pair. It deserialises PS/2 device-to-host frames and checks start, parity and stop bits. It folds 0xE0/0xF0 prefix bytes into key events carrying {ext, release, code} and buffers them in a parametrised FIFO. The host drains events over a valid/ready handshake. Replaces the raw byte path feeding keyboard consumers in the NPC top.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth = 2**FIFO_AW entries).
SYNC_STAGES, 2, flops synchronising ps2_clk and ps2_data (>=2).
TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before abort (used only with PS2_TIMEOUT_EN).

Ports:
clk  input  1  system clock
clrn  input  1  synchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from pad
ps2_data  input  1  raw PS/2 data from pad
ev_valid  output  1  FIFO head holds an event
ev_ready  input  1  consumer accepts head this cycle
ev_code  output  8  scan code of head event
ev_release  output  1  head event is a break (key up)
ev_ext  output  1  head event had 0xE0 prefix
ev_count  output  FIFO_AW+1  events currently buffered
overflow  output  1  sticky: event dropped on full FIFO
frame_err  output  1  sticky: bad start/parity/stop or timeout
clear_err  input  1  clears overflow and frame_err

Behaviour:
- Reset: clrn sampled low at a clk edge clears all state. FIFO empty, decoder IDLE, bit counter 0, shift register 0. ev_valid/ev_code/ev_release/ev_ext/ev_count/overflow/frame_err all 0. A partial frame is discarded.
- Sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops. One further ps2_clk flop for edge detection. Falling edge = previous 1, current 0.
- Bit capture: on each falling edge, sample synchronised ps2_data. Bit counter runs 0..10 (start, d0..d7 LSB first, parity, stop).
  - At bit 0, a sampled 1 is not a start bit: counter stays 0 (resync).
  - At bit 10, counter returns to 0 and the frame is checked.
- Frame check: valid iff stop=1 and d0..d7 plus parity contain an odd number of 1s. Invalid: set frame_err, drop byte, force decoder to IDLE.
- Decoder FSM, one byte per valid frame:
  - IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> emit {ext=0, rel=0}.
  - GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> GOT_E0; other -> emit {ext=1, rel=0}, go IDLE.
  - GOT_F0: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> emit {ext=0, rel=1}, go IDLE.
  - GOT_E0F0: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> emit {ext=1, rel=1}, go IDLE.
- Latency: stop-bit edge detected in cycle E; check and decode registered end of E+1; FIFO write end of E+1; ev_valid high from E+2. No bypass when the FIFO is empty.
- FIFO: 10-bit entries {ext, rel, code}. ev_valid = not empty; ev_* driven from head. Pop when ev_valid && ev_ready. Read/write pointers are FIFO_AW+1 bits and wrap naturally.
- Full: a push while full with no pop in the same cycle drops the event and sets overflow. Push and pop in the same cycle while full: both succeed, count unchanged.
- Empty: ev_ready while empty has no effect. Outputs hold the last head value but ev_valid=0.
- ev_count = write pointer - read pointer, range 0..2**FIFO_AW.
- Sticky flags: clear_err clears overflow and frame_err next edge. A set event in the same cycle wins over clear.

Optional Feature:
PS2_TIMEOUT_EN defined:
- Cycle counter resets on each falling edge and counts while bit counter != 0.
- On reaching TIMEOUT_CYCLES: bit counter -> 0, decoder -> IDLE, frame_err set.
Undefined: no counter is instantiated; a stalled partial frame waits indefinitely.

Test Plan:
- Make code: frame 0x1C (parity 0, stop 1) -> ev_valid at E+2; code 0x1C, rel=0, ext=0, ev_count=1. ev_ready=1 for one cycle -> ev_valid=0.
- Break: frames F0,1C -> exactly one event {0x1C, rel=1, ext=0}.
- Extended break: frames E0,F0,75 -> one event {0x75, rel=1, ext=1}. Then frame 75 -> {0x75, rel=0, ext=0}.
- Errors: frame 0x1C with parity bit flipped -> no event, frame_err=1, decoder IDLE. Frame F0 then bad frame then 1C -> event rel=0. clear_err -> frame_err=0.
- Overflow (FIFO_AW=3): ev_ready=0, send 9 make codes 0x01..0x09 -> ev_count=8, overflow=1. Draining yields 0x01..0x08 in order. Push-while-full with ev_ready=1 -> no overflow.
- Reset and timeout: clrn low after bit 5 then release, next full frame 0x1C -> event 0x1C. With PS2_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop ps2_clk after 4 bits -> frame_err=1 at cycle 100, next frame decodes correctly.
